// File: rtl/UART_pkg.sv
// Shared types and encodings for the parametrised UART transmitter.
// Frame-format codes and FSM state type live here.
package UART_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_BREAK
  } tx_fsm_e;

  localparam logic [2:0] DW_5 = 3'd0;
  localparam logic [2:0] DW_6 = 3'd1;
  localparam logic [2:0] DW_7 = 3'd2;
  localparam logic [2:0] DW_8 = 3'd3;
  localparam logic [2:0] DW_9 = 3'd4;

  localparam logic [1:0] SB_1BIT   = 2'b00;
  localparam logic [1:0] SB_1P5BIT = 2'b01;
  localparam logic [1:0] SB_2BIT   = 2'b10;

  localparam logic [1:0] PAR_EVEN = 2'b00;
  localparam logic [1:0] PAR_ODD  = 2'b01;

  // Width code to number of data bits; reserved codes fall back to 8.
  function automatic logic [3:0] data_bits(input logic [2:0] w);
    if (w <= DW_9) return 4'd5 + {1'b0, w};
    else           return 4'd8;
  endfunction

endpackage

// File: rtl/sync_FIFO_buffer.sv
// Synchronous first-word-fall-through FIFO.
// Head word is visible on data_o whenever the FIFO is non-empty.
module sync_FIFO_buffer #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic                   wr_i,
  input  logic                   rd_i,
  input  logic [WIDTH-1:0]       data_i,
  output logic [WIDTH-1:0]       data_o,
  output logic                   empty_o,
  output logic                   full_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, rptr_q;
  logic [AW:0]      cnt_q;
  logic             wr_en, rd_en;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign count_o = cnt_q;
  assign data_o  = mem_q[rptr_q];
  assign rd_en   = rd_i && !empty_o;
  assign wr_en   = wr_i && (!full_o || rd_en);

  // Storage array, no reset needed.
  always_ff @(posedge clk_i) begin
    if (wr_en) mem_q[wptr_q] <= data_i;
  end

  // Pointers and occupancy.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (wr_en) wptr_q <= wptr_q + 1'b1;
      if (rd_en) rptr_q <= rptr_q + 1'b1;
      if (wr_en && !rd_en)      cnt_q <= cnt_q + 1'b1;
      else if (rd_en && !wr_en) cnt_q <= cnt_q - 1'b1;
    end
  end

endmodule

// File: rtl/param_transmitter.sv
// Parametrised UART transmitter: FIFO-fed framer with CTS and break.
// tx_o is registered and lags the FSM state by one cycle.
module param_transmitter
  import UART_pkg::*;
#(
  parameter int FIFO_DEPTH    = 16,
  parameter int OVERSAMPLE    = 16,
  parameter int MAX_DATA_BITS = 9,
  parameter int BREAK_W       = 8
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          enable_i,
  input  logic                          ov_baud_rt_i,
  input  logic [MAX_DATA_BITS-1:0]      data_tx_i,
  input  logic                          tx_fifo_write_i,
  input  logic [2:0]                    data_width_i,
  input  logic [1:0]                    stop_bits_i,
  input  logic [1:0]                    parity_mode_i,
  input  logic                          cts_en_i,
  input  logic                          cts_n_i,
  input  logic                          break_req_i,
  input  logic [BREAK_W-1:0]            break_len_i,
  output logic                          tx_o,
  output logic                          tx_busy_o,
  output logic                          tx_done_o,
  output logic                          break_done_o,
  output logic                          overflow_o,
  output logic                          tx_fifo_empty_o,
  output logic                          tx_fifo_full_o,
  output logic [$clog2(FIFO_DEPTH):0]   tx_fifo_count_o
);

  localparam int TW = $clog2(OVERSAMPLE*2);
  localparam logic [TW-1:0] T1  = TW'(OVERSAMPLE-1);
  localparam logic [TW-1:0] T15 = TW'(OVERSAMPLE*3/2-1);
  localparam logic [TW-1:0] T2  = TW'(OVERSAMPLE*2-1);

  tx_fsm_e                  state_q, state_d;
  logic [TW-1:0]            tick_q, tick_d;
  logic [3:0]               bit_q, bit_d;
  logic [3:0]               nb_q, nb_d;
  logic [BREAK_W-1:0]       brk_q, brk_d;
  logic [BREAK_W-1:0]       blen_q, blen_d;
  logic                     mark_q, mark_d;
  logic [MAX_DATA_BITS-1:0] shr_q, shr_d;
  logic [1:0]               sb_q, sb_d;
  logic                     pen_q, pen_d;
  logic                     par_q, par_d;
  logic                     tx_q;

  logic [MAX_DATA_BITS-1:0] fifo_dout, masked;
  logic [3:0]               nbits;
  logic                     pop, line, bit_end, stop_end;
  logic [TW-1:0]            stop_lim;

  sync_FIFO_buffer #(
    .WIDTH(MAX_DATA_BITS),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_n_i (!rst_i),
    .wr_i    (tx_fifo_write_i),
    .rd_i    (pop),
    .data_i  (data_tx_i),
    .data_o  (fifo_dout),
    .empty_o (tx_fifo_empty_o),
    .full_o  (tx_fifo_full_o),
    .count_o (tx_fifo_count_o)
  );

  assign nbits      = data_bits(data_width_i);
  assign bit_end    = ov_baud_rt_i && (tick_q == T1);
  assign stop_end   = ov_baud_rt_i && (tick_q == stop_lim);
  assign tx_busy_o  = (state_q != ST_IDLE);
  assign overflow_o = tx_fifo_write_i && tx_fifo_full_o && !pop;
  assign tx_o       = tx_q;

  // Mask off data bits above the configured width.
  always_comb begin
    masked = '0;
    for (int i = 0; i < MAX_DATA_BITS; i++)
      masked[i] = fifo_dout[i] && (4'(i) < nbits);
  end

  // Stop length for the latched format, in ticks minus one.
  always_comb begin
    stop_lim = T2;
    if (sb_q == SB_1BIT)        stop_lim = T1;
    else if (sb_q == SB_1P5BIT) stop_lim = T15;
  end

  // Frame sequencer: next state, line value and strobes.
  always_comb begin
    state_d      = state_q;
    tick_d       = ov_baud_rt_i ? tick_q + 1'b1 : tick_q;
    bit_d        = bit_q;
    nb_d         = nb_q;
    brk_d        = brk_q;
    blen_d       = blen_q;
    mark_d       = mark_q;
    shr_d        = shr_q;
    sb_d         = sb_q;
    pen_d        = pen_q;
    par_d        = par_q;
    pop          = 1'b0;
    line         = 1'b1;
    tx_done_o    = 1'b0;
    break_done_o = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        tick_d = '0;
        if (break_req_i) begin
          state_d = ST_BREAK;
          blen_d  = (break_len_i == '0) ? BREAK_W'(1) : break_len_i;
          brk_d   = '0;
          mark_d  = 1'b0;
        end else if (!tx_fifo_empty_o && enable_i &&
                     (!cts_en_i || !cts_n_i)) begin
          state_d = ST_START;
          pop     = 1'b1;
          shr_d   = masked;
          nb_d    = nbits;
          sb_d    = stop_bits_i;
          pen_d   = !parity_mode_i[1];
          par_d   = (^masked) ^ (parity_mode_i == PAR_ODD);
          bit_d   = '0;
        end
      end
      ST_START: begin
        line = 1'b0;
        if (bit_end) begin
          state_d = ST_DATA;
          tick_d  = '0;
        end
      end
      ST_DATA: begin
        line = shr_q[0];
        if (bit_end) begin
          tick_d = '0;
          shr_d  = shr_q >> 1;
          bit_d  = bit_q + 1'b1;
          if (bit_q == nb_q - 4'd1)
            state_d = pen_q ? ST_PARITY : ST_STOP;
        end
      end
      ST_PARITY: begin
        line = par_q;
        if (bit_end) begin
          state_d = ST_STOP;
          tick_d  = '0;
        end
      end
      ST_STOP: begin
        line = 1'b1;
        if (stop_end) begin
          state_d   = ST_IDLE;
          tick_d    = '0;
          tx_done_o = 1'b1;
        end
      end
      ST_BREAK: begin
        line = mark_q;
        if (bit_end) begin
          tick_d = '0;
          if (mark_q) begin
            state_d      = ST_IDLE;
            break_done_o = 1'b1;
          end else if (brk_q == blen_q - 1'b1) begin
            mark_d = 1'b1;
            brk_d  = '0;
          end else begin
            brk_d = brk_q + 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      tick_q  <= '0;
      bit_q   <= '0;
      nb_q    <= 4'd8;
      brk_q   <= '0;
      blen_q  <= '0;
      mark_q  <= 1'b0;
      shr_q   <= '0;
      sb_q    <= SB_1BIT;
      pen_q   <= 1'b0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      nb_q    <= nb_d;
      brk_q   <= brk_d;
      blen_q  <= blen_d;
      mark_q  <= mark_d;
      shr_q   <= shr_d;
      sb_q    <= sb_d;
      pen_q   <= pen_d;
      par_q   <= par_d;
      tx_q    <= line;
    end
  end

endmodule
